spi_burst_ctrl: RTL

- Host-side sequencer directly upstream of spi_core.
- Accepts bytes from a valid/ready stream into a TX FIFO and issues one spi_core transfer per byte through spi_core's cs/wr/din strobe.
- Waits for spi_core's done, reads spi_core's dout and pushes the received byte into an RX FIFO for the host.
- Turns spi_core's single-shot interface into back-to-back bursts with flow control on both sides.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_sync_fifo.sv | 62 ++++++
 rtl/spi_burst_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI burst sequencer and its FIFOs.
package spi_pkg;

    // Byte width shared with spi_core.
    localparam int unsigned SPI_DWIDTH = 8;

    // Sequencer states, one spi_core transfer per START..READ pass.
    typedef enum logic [2:0] {
        IDLE,
        START,
        GAP,
        WAIT,
        READ
    } spi_state_e;

    // Ceiling log2, used to size FIFO pointers and counters.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and a flush that
// empties it in one cycle. A push coincident with flush lands in the emptied
// FIFO; callers that must discard such pushes gate push_i themselves.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int unsigned DWIDTH = SPI_DWIDTH,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DWIDTH-1:0]     wdata_i,
    input  logic                  pop_i,
    output logic [DWIDTH-1:0]     rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when a pop frees the slot this cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Storage, pointers and occupancy; flush realigns the write pointer to the read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            if (push_i) mem_q[rd_ptr_q] <= wdata_i;
            wr_ptr_q <= rd_ptr_q + AW'(push_i);
            count_q  <= CW'(push_i);
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Host-side sequencer in front of spi_core: drains a TX FIFO one byte per
// spi_core transfer and collects each received byte into an RX FIFO.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DWIDTH = SPI_DWIDTH,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DWIDTH-1:0] tx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DWIDTH-1:0] rx_data,
    input  logic              flush,
    output logic              busy,
    output logic              core_cs,
    output logic              core_wr,
    output logic              core_rd,
    output logic [DWIDTH-1:0] core_din,
    input  logic [DWIDTH-1:0] core_dout,
    input  logic              core_done
);

    localparam int unsigned CW = clog2(DEPTH) + 1;

    spi_state_e        state_q;
    logic              core_cs_q;
    logic              core_wr_q;
    logic              core_rd_q;
    logic [DWIDTH-1:0] core_din_q;

    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [DWIDTH-1:0] tx_head;
    logic [CW-1:0]     tx_count;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [CW-1:0]     rx_count;
    logic              issue_ok;
    logic              unused_status;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign busy     = (state_q != IDLE);
    assign core_cs  = core_cs_q;
    assign core_wr  = core_wr_q;
    assign core_rd  = core_rd_q;
    assign core_din = core_din_q;

    // Host pushes coincident with flush are dropped; the READ push is not,
    // so an in-flight byte still lands in the freshly emptied RX FIFO.
    assign tx_push = tx_valid && tx_ready && !flush;
    assign tx_pop  = (state_q == START);
    assign rx_push = (state_q == READ);
    assign rx_pop  = rx_ready && !rx_empty;

    // Issue happens only from IDLE, where no byte is in flight, so a free RX
    // slot is simply "not full"; that slot is reserved until READ fills it.
    assign issue_ok = !tx_empty && !rx_full && !flush;

    assign unused_status = ^{tx_count, rx_count};

    spi_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (tx_push),
        .wdata_i (tx_data),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    spi_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (rx_push),
        .wdata_i (core_dout),
        .pop_i   (rx_pop),
        .rdata_o (rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // Transfer sequencer with registered spi_core strobes; GAP masks a stale done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            core_cs_q  <= 1'b0;
            core_wr_q  <= 1'b0;
            core_rd_q  <= 1'b0;
            core_din_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_ok) begin
                        state_q    <= START;
                        core_cs_q  <= 1'b1;
                        core_wr_q  <= 1'b1;
                        core_din_q <= tx_head;
                    end
                end
                START: begin
                    state_q   <= GAP;
                    core_cs_q <= 1'b0;
                    core_wr_q <= 1'b0;
                end
                GAP: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        state_q   <= READ;
                        core_cs_q <= 1'b1;
                        core_rd_q <= 1'b1;
                    end
                end
                READ: begin
                    state_q   <= IDLE;
                    core_cs_q <= 1'b0;
                    core_rd_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    core_cs_q <= 1'b0;
                    core_wr_q <= 1'b0;
                    core_rd_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
